reg_packer: RTL and testbench
=============================

Name: reg_packer

Overview:
- Byte-to-word assembler: the receive-side counterpart of the 32-bit-to-byte register splitter.
- Collects four byte strobes into one 32-bit register word, MSB-first, and presents it on a valid/ready output handshake.
- Sits between the byte-wide ADC/config link and the 32-bit register bank.
- Can accumulate the next word's leading bytes while the previous word waits for the sink.

Parameters:
TIMEOUT_CYCLES, 1024, idle cycles after which a partial word is discarded (used only with REG_PACKER_TIMEOUT_EN; must be >= 2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
write  in  1  byte strobe, one byte per cycle when high
byte_in  in  8  byte data, sampled when write && byte_ready
flush  in  1  discard partial word and resync byte counter
byte_ready  out  1  packer can accept a byte this cycle
word_out  out  32  assembled word, stable while word_valid
word_valid  out  1  word_out holds an unconsumed word
word_ready  in  1  sink accepts word when word_valid && word_ready
byte_cnt  out  2  bytes held in the partial word (0..3)
overrun  out  1  sticky: a byte arrived while byte_ready was low
clear_ovr  in  1  clears overrun
timeout  out  1  one-cycle pulse on partial-word timeout (0 when feature absent)

Behaviour:
- Reset (synchronous, rst high at a clk edge): byte_cnt=0, word_valid=0, word_out=32'd0, overrun=0, timeout=0, partial register=0, idle counter=0. rst overrides every other input. Reset mid-word or with a word pending discards everything.
- Byte order: accepted byte k (k=0..3) goes to partial bits [31-8k -: 8]. The first byte lands in [31:24] and the last in [7:0].
- Accept condition: acc = write && byte_ready. On acc, byte_cnt increments mod 4.
- On acc with byte_cnt==3:
  - partial[31:8] concatenated with byte_in is loaded into word_out.
  - word_valid=1 on the next cycle (latency 1 clk from the 4th byte).
  - byte_cnt returns to 0.
- byte_ready = !(byte_cnt==3 && word_valid && !word_ready) && !rst.
  - Bytes 0..2 of the next word are always accepted.
  - The 4th byte stalls only while the sink holds off.
  - If word_ready is high in the same cycle as the 4th byte, the old word is consumed and the new word loaded; word_valid stays 1.
- Output handshake: word_valid && word_ready with no new completion sets word_valid=0 next cycle. word_out holds its value while word_valid=1 && !word_ready.
- Overrun:
  - write && !byte_ready sets overrun=1 next cycle; the byte is dropped and byte_cnt is unchanged.
  - clear_ovr clears overrun; if a set and clear_ovr occur in the same cycle, set wins.
- Flush:
  - Sets byte_cnt=0 and discards partial bytes.
  - Does not touch word_out/word_valid.
  - flush && write in the same cycle: flush first, then byte_in is accepted as byte 0 (byte_cnt=1 next cycle); byte_ready is unaffected by flush.
- Word-only interface: no partial word is ever emitted.

Optional Feature:
REG_PACKER_TIMEOUT_EN:
- Defined:
  - Idle counter is cleared on any acc, flush or rst, and whenever byte_cnt==0.
  - Otherwise it increments while byte_cnt!=0 and no acc.
  - On reaching TIMEOUT_CYCLES-1: byte_cnt=0, partial discarded, timeout=1 for exactly one cycle, counter=0.
  - acc in the timeout cycle wins: the byte is accepted, no timeout fires.
- Undefined: no counter logic, timeout tied to 0, partial bytes held indefinitely.

Test Plan:
- Reset, then writes 0xDE,0xAD,0xBE,0xEF on consecutive cycles with word_ready=1 -> word_valid one cycle after 0xEF, word_out=0xDEADBEEF, valid for one cycle, byte_cnt sequence 1,2,3,0.
- word_ready=0, send 0x11223344 then 0x55,0x66,0x77,0x88 -> first three accepted (byte_cnt=3), byte_ready=0 on the 4th, word_out holds 0x11223344; raise word_ready -> 0x88 accepted, next word 0x55667788.
- Continue writing 0x99 while byte_ready=0 -> overrun=1, byte dropped, byte_cnt stays 3; clear_ovr -> overrun=0.
- Write 0xAA,0xBB, then flush+write 0x01 same cycle, then 0x02,0x03,0x04 -> word_out=0x01020304, byte_cnt=1 after the flush cycle.
- Assert rst after two bytes and with a pending word -> next cycle word_valid=0, byte_cnt=0, word_out=0; subsequent 4 bytes produce a clean word.
- With REG_PACKER_TIMEOUT_EN, TIMEOUT_CYCLES=8: write 0xAA then idle -> timeout pulse exactly 8 cycles after acceptance, byte_cnt=0; without macro, timeout stays 0 and byte_cnt stays 1.

Source files
------------

// File: rtl/reg_packer_if.sv
// Byte-in / word-out handshake bundle for reg_packer.
// master = byte source and word sink side; slave = the packer itself.
interface reg_packer_if;
  logic        write;
  logic [7:0]  byte_in;
  logic        byte_ready;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output write, byte_in, word_ready,
    input  byte_ready, word_out, word_valid
  );

  modport slave (
    input  write, byte_in, word_ready,
    output byte_ready, word_out, word_valid
  );
endinterface

// File: rtl/reg_packer.sv
// Byte-to-word assembler: four bytes MSB-first into a 32-bit word on a valid/ready output.
// Optional partial-word idle timeout is enabled by defining REG_PACKER_TIMEOUT_EN.
module reg_packer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst,
  reg_packer_if.slave    bus,
  input  logic           flush,
  output logic [1:0]     byte_cnt,
  output logic           overrun,
  input  logic           clear_ovr,
  output logic           timeout
);

  if (TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("reg_packer: TIMEOUT_CYCLES must be >= 2");
  end

  logic [1:0]  cnt_q, cnt_d, cnt_base;
  logic [31:0] part_q, part_d, part_base;
  logic [31:0] wo_q, wo_d;
  logic        wv_q, wv_d;
  logic        ovr_q, ovr_d;
  logic        acc, complete;

  // Only the completing byte can stall, and only while the old word is still held off.
  assign bus.byte_ready = !(cnt_q == 2'd3 && wv_q && !bus.word_ready) && !rst;
  assign acc            = bus.write && bus.byte_ready;

`ifdef REG_PACKER_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              to_q, to_d;
`endif

  always_comb begin
    // Flush is applied first so a same-cycle byte lands as byte 0.
    cnt_base  = flush ? 2'd0 : cnt_q;
    part_base = flush ? 32'd0 : part_q;
    cnt_d     = cnt_base;
    part_d    = part_base;
    wo_d      = wo_q;
    wv_d      = wv_q;
    ovr_d     = ovr_q;
    complete  = 1'b0;

    if (acc) begin
      if (cnt_base == 2'd3) begin
        complete = 1'b1;
        wo_d     = {part_base[31:8], bus.byte_in};
        cnt_d    = 2'd0;
        part_d   = 32'd0;
      end else begin
        cnt_d = cnt_base + 2'd1;
        case (cnt_base)
          2'd0:    part_d[31:24] = bus.byte_in;
          2'd1:    part_d[23:16] = bus.byte_in;
          default: part_d[15:8]  = bus.byte_in;
        endcase
      end
    end

    if (complete)                      wv_d = 1'b1;
    else if (wv_q && bus.word_ready)   wv_d = 1'b0;

    // Set beats clear when both happen together.
    if (clear_ovr)                         ovr_d = 1'b0;
    if (bus.write && !bus.byte_ready)      ovr_d = 1'b1;

`ifdef REG_PACKER_TIMEOUT_EN
    to_d   = 1'b0;
    idle_d = idle_q;
    if (acc || flush || cnt_q == 2'd0) begin
      idle_d = '0;
    end else if (idle_q == IDLE_MAX) begin
      cnt_d  = 2'd0;
      part_d = 32'd0;
      to_d   = 1'b1;
      idle_d = '0;
    end else begin
      idle_d = idle_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      part_q <= 32'd0;
      wo_q   <= 32'd0;
      wv_q   <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef REG_PACKER_TIMEOUT_EN
      idle_q <= '0;
      to_q   <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      part_q <= part_d;
      wo_q   <= wo_d;
      wv_q   <= wv_d;
      ovr_q  <= ovr_d;
`ifdef REG_PACKER_TIMEOUT_EN
      idle_q <= idle_d;
      to_q   <= to_d;
`endif
    end
  end

  assign bus.word_out   = wo_q;
  assign bus.word_valid = wv_q;
  assign byte_cnt       = cnt_q;
  assign overrun        = ovr_q;
`ifdef REG_PACKER_TIMEOUT_EN
  assign timeout        = to_q;
`else
  assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_reg_packer.sv
// Self-checking bench for reg_packer: directed scenarios plus random traffic against a queue model.
module tb_reg_packer;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst, flush, clear_ovr;
  logic [1:0] byte_cnt;
  logic       overrun, timeout;
  int         total = 0, bad = 0;

  reg_packer_if bus();

  reg_packer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush), .byte_cnt(byte_cnt),
    .overrun(overrun), .clear_ovr(clear_ovr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: pending bytes as a queue, output word as plain state.
  logic [7:0]  m_q[$];
  logic        m_wv, m_ovr, m_to;
  logic [31:0] m_wo;
`ifdef REG_PACKER_TIMEOUT_EN
  int          m_idle;
`endif
  logic        obs_rdy, exp_rdy;

  // Applies one cycle of inputs, samples byte_ready mid-cycle, advances the model.
  task automatic tick(input logic w, input logic [7:0] b, input logic fl,
                      input logic wr, input logic co, input logic rs);
    logic acc, done, had;
    logic [31:0] nw;
    bus.write = w; bus.byte_in = b; flush = fl; bus.word_ready = wr;
    clear_ovr = co; rst = rs;
    #4;
    obs_rdy = bus.byte_ready;
    exp_rdy = !(m_q.size() == 3 && m_wv && !wr) && !rs;
    acc  = w && exp_rdy;
    done = 1'b0;
    nw   = 32'd0;
    @(posedge clk);
    if (rs) begin
      m_q.delete(); m_wv = 0; m_wo = 0; m_ovr = 0; m_to = 0;
`ifdef REG_PACKER_TIMEOUT_EN
      m_idle = 0;
`endif
    end else begin
      had = (m_q.size() != 0);
      if (fl) m_q.delete();
      if (acc) begin
        m_q.push_back(b);
        if (m_q.size() == 4) begin
          nw = {m_q[0], m_q[1], m_q[2], m_q[3]};
          m_q.delete();
          done = 1'b1;
        end
      end
      if (done) begin m_wv = 1; m_wo = nw; end
      else if (m_wv && wr) m_wv = 0;
      if (w && !exp_rdy) m_ovr = 1;
      else if (co) m_ovr = 0;
      m_to = 0;
`ifdef REG_PACKER_TIMEOUT_EN
      if (acc || fl || !had) m_idle = 0;
      else if (m_idle == TO - 1) begin m_q.delete(); m_to = 1; m_idle = 0; end
      else m_idle++;
`else
      if (had) m_to = 0;
`endif
    end
    #1;
  endtask

  task automatic test_reset;
    tick(0, 8'h00, 0, 0, 0, 1);
    total++; if (obs_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b want 0", obs_rdy); end
    tick(0, 8'h00, 0, 0, 0, 1);
    total++;
    if (byte_cnt !== 2'd0 || bus.word_valid !== 1'b0 || bus.word_out !== 32'd0 ||
        overrun !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got cnt=%0d wv=%b wo=%h ovr=%b to=%b want all zero",
               byte_cnt, bus.word_valid, bus.word_out, overrun, timeout);
    end
  endtask

  task automatic test_basic;
    logic [7:0] bs [4];
    logic [1:0] ec [4];
    bs = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    ec = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      tick(1, bs[i], 0, 1, 0, 0);
      total++; if (byte_cnt !== ec[i]) begin bad++; $display("FAIL basic_cnt%0d: got %0d want %0d", i, byte_cnt, ec[i]); end
      total++; if (bus.word_valid !== (i == 3)) begin bad++; $display("FAIL basic_wv%0d: got %b want %b", i, bus.word_valid, i == 3); end
    end
    total++; if (bus.word_out !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_word: got %h want deadbeef", bus.word_out); end
    tick(0, 8'h00, 0, 1, 0, 0);
    total++; if (bus.word_valid !== 1'b0) begin bad++; $display("FAIL basic_consume: got %b want 0", bus.word_valid); end
  endtask

  task automatic test_backpressure;
    logic [7:0] bs [7];
    bs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    for (int i = 0; i < 7; i++) tick(1, bs[i], 0, 0, 0, 0);
    total++; if (byte_cnt !== 2'd3) begin bad++; $display("FAIL bp_cnt: got %0d want 3", byte_cnt); end
    total++; if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h11223344) begin
      bad++; $display("FAIL bp_hold: got wv=%b wo=%h want 1/11223344", bus.word_valid, bus.word_out); end
    tick(1, 8'h99, 0, 0, 0, 0);
    total++; if (obs_rdy !== 1'b0) begin bad++; $display("FAIL bp_stall: got rdy=%b want 0", obs_rdy); end
    total++; if (overrun !== 1'b1 || byte_cnt !== 2'd3) begin
      bad++; $display("FAIL ovr_set: got ovr=%b cnt=%0d want 1/3", overrun, byte_cnt); end
    tick(0, 8'h00, 0, 0, 1, 0);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    tick(1, 8'h88, 0, 1, 0, 0);
    total++; if (obs_rdy !== 1'b1) begin bad++; $display("FAIL bp_release: got rdy=%b want 1", obs_rdy); end
    total++; if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h55667788 || byte_cnt !== 2'd0) begin
      bad++; $display("FAIL bp_word2: got wv=%b wo=%h cnt=%0d want 1/55667788/0", bus.word_valid, bus.word_out, byte_cnt); end
    tick(0, 8'h00, 0, 1, 0, 0);
    total++; if (bus.word_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", bus.word_valid); end
  endtask

  task automatic test_flush;
    tick(1, 8'hAA, 0, 1, 0, 0);
    tick(1, 8'hBB, 0, 1, 0, 0);
    tick(1, 8'h01, 1, 1, 0, 0);
    total++; if (byte_cnt !== 2'd1) begin bad++; $display("FAIL flush_cnt: got %0d want 1", byte_cnt); end
    tick(1, 8'h02, 0, 1, 0, 0);
    tick(1, 8'h03, 0, 1, 0, 0);
    tick(1, 8'h04, 0, 1, 0, 0);
    total++; if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h01020304) begin
      bad++; $display("FAIL flush_word: got wv=%b wo=%h want 1/01020304", bus.word_valid, bus.word_out); end
    tick(0, 8'h00, 0, 1, 0, 0);
  endtask

  task automatic test_reset_mid;
    logic [7:0] bs [6];
    bs = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1};
    for (int i = 0; i < 6; i++) tick(1, bs[i], 0, 0, 0, 0);
    tick(1, 8'hE0, 0, 0, 0, 1);
    total++; if (bus.word_valid !== 1'b0 || byte_cnt !== 2'd0 || bus.word_out !== 32'd0) begin
      bad++; $display("FAIL rst_mid: got wv=%b cnt=%0d wo=%h want 0/0/0", bus.word_valid, byte_cnt, bus.word_out); end
    tick(1, 8'hF1, 0, 0, 0, 0);
    tick(1, 8'hF2, 0, 0, 0, 0);
    tick(1, 8'hF3, 0, 0, 0, 0);
    tick(1, 8'hF4, 0, 0, 0, 0);
    total++; if (bus.word_valid !== 1'b1 || bus.word_out !== 32'hF1F2F3F4) begin
      bad++; $display("FAIL rst_clean: got wv=%b wo=%h want 1/f1f2f3f4", bus.word_valid, bus.word_out); end
    tick(0, 8'h00, 0, 1, 0, 0);
  endtask

  task automatic test_timeout;
    logic       exp_to;
    logic [1:0] exp_c;
    tick(1, 8'hAA, 0, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      tick(0, 8'h00, 0, 1, 0, 0);
`ifdef REG_PACKER_TIMEOUT_EN
      exp_to = (i == TO);
      exp_c  = (i >= TO) ? 2'd0 : 2'd1;
`else
      exp_to = 1'b0;
      exp_c  = 2'd1;
`endif
      total++; if (timeout !== exp_to || byte_cnt !== exp_c) begin
        bad++; $display("FAIL timeout_c%0d: got to=%b cnt=%0d want %b/%0d", i, timeout, byte_cnt, exp_to, exp_c); end
    end
    tick(0, 8'h00, 1, 1, 0, 0);
  endtask

  task automatic test_random;
    int wprob;
    for (int i = 0; i < 3000; i++) begin
      wprob = ((i / 250) % 2 == 0) ? 70 : 12;
      tick($urandom_range(0, 99) < wprob, 8'($urandom), $urandom_range(0, 99) < 4,
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
      total++;
      if (obs_rdy !== exp_rdy || byte_cnt !== 2'(m_q.size()) || bus.word_valid !== m_wv ||
          bus.word_out !== m_wo || overrun !== m_ovr || timeout !== m_to) begin
        bad++;
        $display("FAIL rand%0d: got rdy=%b cnt=%0d wv=%b wo=%h ovr=%b to=%b want %b/%0d/%b/%h/%b/%b",
                 i, obs_rdy, byte_cnt, bus.word_valid, bus.word_out, overrun, timeout,
                 exp_rdy, m_q.size(), m_wv, m_wo, m_ovr, m_to);
      end
    end
  endtask

  initial begin
    rst = 1; flush = 0; clear_ovr = 0;
    bus.write = 0; bus.byte_in = 0; bus.word_ready = 0;
    m_wv = 0; m_wo = 0; m_ovr = 0; m_to = 0;
`ifdef REG_PACKER_TIMEOUT_EN
    m_idle = 0;
`endif
    @(posedge clk); #1;
    test_reset;
    test_basic;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_timeout;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
